// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data accesses. Each access runs for MEM_LAT cycles, pulses mem_en on its
// first cycle and the owner's grant on its last, then returns to IDLE for
// at least one bubble cycle before the next arbitration.
// Optional build macro: ARB_RR_EN selects round-robin contention resolution;
// when it is undefined, data requests have fixed priority over fetch.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  output logic sel,
  output logic mem_en,
  output logic if_gnt,
  output logic dm_gnt,
  output logic busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       sel_q, sel_d;
  logic       winner;

  // Pick who gets the port when arbitration happens (1 = data, 0 = fetch).
  always_comb begin
`ifdef ARB_RR_EN
    // Under contention the requester that did not own the last access wins.
    winner = (if_req && dm_req) ? ~owner_q : dm_req;
`else
    // Data always beats fetch; a lone fetch request still wins.
    winner = dm_req;
`endif
  end

  // Next-state logic: start an access from IDLE, count it down in ACCESS.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d = ACCESS;
          cnt_d   = LAT4;
          owner_d = winner;
          sel_d   = winner;
        end
      end
      ACCESS: begin
        // The cycle with cnt==1 is the grant cycle; its closing edge ends
        // the access, which guarantees an IDLE bubble between accesses.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      owner_q <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      sel_q   <= sel_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    busy   = (state_q == ACCESS);
    sel    = sel_q;
    mem_en = busy && (cnt_q == LAT4);
    if_gnt = busy && (cnt_q == 4'd1) && !owner_q;
    dm_gnt = busy && (cnt_q == 4'd1) && owner_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT = 1, 2, 3) share the
// clock and reset. A transaction-level model tracks each instance's access
// as an age counted from its start; every cycle the outputs are compared to
// it, and directed sequences pin the model with literal expectations.
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] ifr, dmr;
  logic [2:0] sel, men, ig, dg, bz;

  int total = 0;
  int bad   = 0;

  localparam int LATS [3] = '{1, 2, 3};

  mem_port_arbiter #(.MEM_LAT(1)) u_l1 (
    .clk(clk), .rst(rst), .if_req(ifr[0]), .dm_req(dmr[0]),
    .sel(sel[0]), .mem_en(men[0]), .if_gnt(ig[0]), .dm_gnt(dg[0]), .busy(bz[0])
  );
  mem_port_arbiter #(.MEM_LAT(2)) u_l2 (
    .clk(clk), .rst(rst), .if_req(ifr[1]), .dm_req(dmr[1]),
    .sel(sel[1]), .mem_en(men[1]), .if_gnt(ig[1]), .dm_gnt(dg[1]), .busy(bz[1])
  );
  mem_port_arbiter #(.MEM_LAT(3)) u_l3 (
    .clk(clk), .rst(rst), .if_req(ifr[2]), .dm_req(dmr[2]),
    .sel(sel[2]), .mem_en(men[2]), .if_gnt(ig[2]), .dm_gnt(dg[2]), .busy(bz[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit m_act [3];
  int m_age [3];
  bit m_own [3];
  bit m_sel [3];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] <= 1'b0;
        m_age[i] <= 0;
        m_own[i] <= 1'b1;
        m_sel[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_act[i]) begin
          if (m_age[i] == LATS[i]) m_act[i] <= 1'b0;
          else m_age[i] <= m_age[i] + 1;
        end else if (ifr[i] || dmr[i]) begin
          bit w;
          if (ifr[i] && dmr[i]) begin
`ifdef ARB_RR_EN
            w = !m_own[i];
`else
            w = 1'b1;
`endif
          end else begin
            w = dmr[i];
          end
          m_act[i] <= 1'b1;
          m_age[i] <= 1;
          m_own[i] <= w;
          m_sel[i] <= w;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        bit last;
        last = m_act[i] && (m_age[i] == LATS[i]);
        chk($sformatf("busy[%0d]", i), int'(bz[i]), int'(m_act[i]));
        chk($sformatf("sel[%0d]", i), int'(sel[i]), int'(m_sel[i]));
        chk($sformatf("mem_en[%0d]", i), int'(men[i]), int'(m_act[i] && m_age[i] == 1));
        chk($sformatf("if_gnt[%0d]", i), int'(ig[i]), int'(last && !m_own[i]));
        chk($sformatf("dm_gnt[%0d]", i), int'(dg[i]), int'(last && m_own[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    ifr = '0;
    dmr = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  int gown[$];
  int gcyc[$];
  int exp_own [3];

  initial begin
    rst = 1'b1;
    ifr = '0;
    dmr = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", int'(bz), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_men", int'(men), 0);
    chk("rst_gnt", int'(ig | dg), 0);
    tick();
    rst = 1'b0;
    tick();

    // Lone fetch, MEM_LAT=2.
    ifr[1] = 1'b1;
    @(negedge clk); chk("f2_pre_busy", int'(bz[1]), 0);
    tick(); @(negedge clk);
    chk("f2_c1_men", int'(men[1]), 1); chk("f2_c1_busy", int'(bz[1]), 1);
    chk("f2_c1_sel", int'(sel[1]), 0); chk("f2_c1_ig", int'(ig[1]), 0);
    tick(); @(negedge clk);
    chk("f2_c2_ig", int'(ig[1]), 1); chk("f2_c2_men", int'(men[1]), 0);
    chk("f2_c2_busy", int'(bz[1]), 1); chk("f2_c2_sel", int'(sel[1]), 0);
    tick(); ifr[1] = 1'b0; @(negedge clk);
    chk("f2_c3_busy", int'(bz[1]), 0); chk("f2_c3_ig", int'(ig[1]), 0);
    drain(3);

    // Continuous contention, MEM_LAT=2, starting fresh from reset.
    rst_pulse();
    tick();
    ifr[1] = 1'b1;
    dmr[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(); @(negedge clk);
      if (ig[1]) begin gown.push_back(0); gcyc.push_back(c); end
      if (dg[1]) begin gown.push_back(1); gcyc.push_back(c); end
    end
`ifdef ARB_RR_EN
    exp_own = '{0, 1, 0};
`else
    exp_own = '{1, 1, 1};
`endif
    chk("cont_ngrants", gown.size(), 3);
    if (gown.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("cont_owner%0d", k), gown[k], exp_own[k]);
        chk($sformatf("cont_cycle%0d", k), gcyc[k], 1 + 3 * k);
      end
    end
    drain(4);

    // Lone data request, MEM_LAT=1: everything in one cycle.
    dmr[0] = 1'b1;
    tick(); @(negedge clk);
    chk("d1_men", int'(men[0]), 1); chk("d1_dg", int'(dg[0]), 1);
    chk("d1_busy", int'(bz[0]), 1); chk("d1_sel", int'(sel[0]), 1);
    tick(); dmr[0] = 1'b0; @(negedge clk);
    chk("d1_after_busy", int'(bz[0]), 0);
    drain(2);

    // Reset mid-access, MEM_LAT=3.
    ifr[2] = 1'b1;
    tick(); @(negedge clk); chk("r3_c1_men", int'(men[2]), 1);
    tick();
    rst = 1'b1;
    #1;
    chk("r3_rst_busy", int'(bz[2]), 0); chk("r3_rst_men", int'(men[2]), 0);
    chk("r3_rst_ig", int'(ig[2]), 0); chk("r3_rst_dg", int'(dg[2]), 0);
    chk("r3_rst_sel", int'(sel[2]), 0);
    #1;
    rst = 1'b0;
    @(negedge clk); chk("r3_idle_busy", int'(bz[2]), 0);
    tick(); @(negedge clk);
    chk("r3_restart_men", int'(men[2]), 1); chk("r3_restart_busy", int'(bz[2]), 1);
    tick(); tick(); @(negedge clk);
    chk("r3_restart_ig", int'(ig[2]), 1);
    tick(); ifr[2] = 1'b0;
    drain(3);

    // Data request arriving during a fetch, MEM_LAT=2.
    ifr[1] = 1'b1;
    tick(); dmr[1] = 1'b1; @(negedge clk);
    chk("q_c1_sel", int'(sel[1]), 0); chk("q_c1_men", int'(men[1]), 1);
    tick(); @(negedge clk);
    chk("q_c2_ig", int'(ig[1]), 1); chk("q_c2_sel", int'(sel[1]), 0);
    chk("q_c2_dg", int'(dg[1]), 0);
    tick(); ifr[1] = 1'b0; @(negedge clk);
    chk("q_bub_busy", int'(bz[1]), 0); chk("q_bub_sel", int'(sel[1]), 0);
    tick(); @(negedge clk);
    chk("q_d_men", int'(men[1]), 1); chk("q_d_sel", int'(sel[1]), 1);
    tick(); @(negedge clk);
    chk("q_d_dg", int'(dg[1]), 1);
    tick(); dmr[1] = 1'b0;
    drain(3);

    // Data request dropped after mem_en, MEM_LAT=3.
    dmr[2] = 1'b1;
    tick(); @(negedge clk); chk("x_c1_men", int'(men[2]), 1);
    tick(); dmr[2] = 1'b0; @(negedge clk);
    chk("x_c2_dg", int'(dg[2]), 0); chk("x_c2_busy", int'(bz[2]), 1);
    tick(); @(negedge clk);
    chk("x_c3_dg", int'(dg[2]), 1); chk("x_c3_sel", int'(sel[2]), 1);
    tick(); @(negedge clk);
    chk("x_c4_busy", int'(bz[2]), 0);
    drain(2);

    // Randomized traffic with varying request density and rare resets.
    for (int blk = 0; blk < 30; blk++) begin
      int dens;
      dens = $urandom_range(1, 4);
      for (int c = 0; c < 100; c++) begin
        tick();
        if ($urandom_range(0, 249) == 0) rst_pulse();
        for (int i = 0; i < 3; i++) begin
          ifr[i] = ($urandom_range(0, 4) < dens);
          dmr[i] = ($urandom_range(0, 4) < dens);
        end
      end
    end
    drain(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
